// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// hazard_pkg : forward-select codes and pipeline shadow-stage record
// Rev 1.0
// ============================================================================
package hazard_pkg;

   // Upper bound on REG_AW; narrower register addresses are zero-extended.
   localparam int DEST_W = 8;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_EX  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;
   localparam logic [1:0] FWD_WB  = 2'b11;

   typedef struct packed {
      logic              valid;
      logic [DEST_W-1:0] dest;
      logic              wreg;
      logic              load;
      logic              multi;
   } stage_t;

   localparam stage_t STAGE_BUBBLE = '0;

   // A stage can supply source x only if it will write a real (non-zero) register.
   function automatic logic stage_hit(stage_t s, logic [DEST_W-1:0] x, logic used);
      return s.valid & s.wreg & used & (s.dest == x) & (x != '0);
   endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_lat_counter.sv
`default_nettype none
// ============================================================================
// mdu_lat_counter : remaining-cycle counter for a multi-cycle op in EX
// Rev 1.0
// ============================================================================
module mdu_lat_counter #(
   parameter  int MDU_LAT = 4,
   localparam int CW      = $clog2(MDU_LAT) + 1
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic dec,
   output logic busy
);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = CW'(MDU_LAT - 1);
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign busy = (cnt_q != '0);

endmodule
`default_nettype wire

// File: rtl/hazard_fwd_unit.sv
`default_nettype none
// ============================================================================
// hazard_fwd_unit : operand forwarding, stall/bubble and IF flush for ID
// Rev 1.0
// ============================================================================
module hazard_fwd_unit #(
   parameter int REG_AW  = 5,
   parameter bit FWD_WB  = 1'b1,
   parameter int MDU_LAT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs,
   input  logic              id_rs_used,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_rt_used,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_wreg,
   input  logic              id_m2reg,
   input  logic              id_multi,
   input  logic              id_branch_taken,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b,
   output logic              stall,
   output logic              flush_if,
   output logic              mdu_busy
);
   import hazard_pkg::*;

   stage_t ex_q, ex_d;
   stage_t mem_q, mem_d;
   stage_t wb_q, wb_d;
   stage_t id_stage;

   logic [DEST_W-1:0] rs_x, rt_x;
   logic ex_hit_a, mem_hit_a, wb_hit_a;
   logic ex_hit_b, mem_hit_b, wb_hit_b;
   logic load_use, wb_block, issue, cnt_busy;
   logic wb_unused;

   function automatic logic [1:0] pick(logic e, logic m, logic w);
      if (e)                return FWD_EX;
      else if (m)           return FWD_MEM;
      else if (w && FWD_WB) return hazard_pkg::FWD_WB;
      return FWD_RF;
   endfunction

   always_comb begin
      rs_x      = DEST_W'(id_rs);
      rt_x      = DEST_W'(id_rt);
      ex_hit_a  = stage_hit(ex_q,  rs_x, id_rs_used);
      mem_hit_a = stage_hit(mem_q, rs_x, id_rs_used);
      wb_hit_a  = stage_hit(wb_q,  rs_x, id_rs_used);
      ex_hit_b  = stage_hit(ex_q,  rt_x, id_rt_used);
      mem_hit_b = stage_hit(mem_q, rt_x, id_rt_used);
      wb_hit_b  = stage_hit(wb_q,  rt_x, id_rt_used);

      fwd_a = pick(ex_hit_a, mem_hit_a, wb_hit_a);
      fwd_b = pick(ex_hit_b, mem_hit_b, wb_hit_b);

      mdu_busy = ex_q.valid & ex_q.multi & cnt_busy;
      load_use = (ex_hit_a | ex_hit_b) & ex_q.load;
      // Without write-through, a WB-only producer must drain into the regfile first.
      wb_block = !FWD_WB &
                 ((wb_hit_a & ~ex_hit_a & ~mem_hit_a) |
                  (wb_hit_b & ~ex_hit_b & ~mem_hit_b));
      stall    = id_valid & (load_use | mdu_busy | wb_block);
      flush_if = id_valid & id_branch_taken & ~stall;
      issue    = ~mdu_busy & ~stall;
   end

   always_comb begin
      id_stage       = STAGE_BUBBLE;
      id_stage.valid = id_valid;
      id_stage.dest  = DEST_W'(id_rd);
      id_stage.wreg  = id_wreg;
      id_stage.load  = id_m2reg;
      id_stage.multi = id_multi;

      ex_d  = id_stage;
      mem_d = ex_q;
      wb_d  = mem_q;
      if (mdu_busy) begin
         ex_d  = ex_q;
         mem_d = STAGE_BUBBLE;
      end else if (stall) begin
         ex_d  = STAGE_BUBBLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_q  <= STAGE_BUBBLE;
         mem_q <= STAGE_BUBBLE;
         wb_q  <= STAGE_BUBBLE;
      end else begin
         ex_q  <= ex_d;
         mem_q <= mem_d;
         wb_q  <= wb_d;
      end
   end

   mdu_lat_counter #(
      .MDU_LAT (MDU_LAT)
   ) u_mdu_cnt (
      .clk  (clk),
      .rst  (rst),
      .load (issue & id_valid & id_multi),
      .dec  (mdu_busy),
      .busy (cnt_busy)
   );

   assign wb_unused = wb_q.load ^ wb_q.multi;

endmodule
`default_nettype wire

// File: tb/tb_hazard_fwd_unit.sv
`default_nettype none
// ============================================================================
// tb_hazard_fwd_unit : three configurations driven in lockstep vs. a record model
// Rev 1.0
// ============================================================================
module tb_hazard_fwd_unit;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       id_valid = 1'b0;
   logic [4:0] id_rs = '0;
   logic       id_rs_used = 1'b0;
   logic [4:0] id_rt = '0;
   logic       id_rt_used = 1'b0;
   logic [4:0] id_rd = '0;
   logic       id_wreg = 1'b0;
   logic       id_m2reg = 1'b0;
   logic       id_multi = 1'b0;
   logic       id_branch_taken = 1'b0;

   logic [1:0] fa [3];
   logic [1:0] fb [3];
   logic       st [3];
   logic       fl [3];
   logic       mb [3];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // Instance 0: FWD_WB=1/LAT=4, 1: FWD_WB=0/LAT=4, 2: FWD_WB=1/LAT=1
   for (genvar i = 0; i < 3; i++) begin : g_dut
      localparam bit FW = (i == 1) ? 1'b0 : 1'b1;
      localparam int LT = (i == 2) ? 1 : 4;
      hazard_fwd_unit #(.REG_AW(5), .FWD_WB(FW), .MDU_LAT(LT)) dut (
         .clk(clk), .rst(rst), .id_valid(id_valid),
         .id_rs(id_rs), .id_rs_used(id_rs_used),
         .id_rt(id_rt), .id_rt_used(id_rt_used),
         .id_rd(id_rd), .id_wreg(id_wreg), .id_m2reg(id_m2reg),
         .id_multi(id_multi), .id_branch_taken(id_branch_taken),
         .fwd_a(fa[i]), .fwd_b(fb[i]), .stall(st[i]),
         .flush_if(fl[i]), .mdu_busy(mb[i]));
   end

   // Reference model: one record per in-flight instruction plus cycles left in EX.
   typedef struct {
      bit valid;
      int dest;
      bit wreg;
      bit load;
      bit multi;
   } ent_t;

   ent_t mex [3];
   ent_t mmem[3];
   ent_t mwb [3];
   int   mrem[3];
   ent_t empty_ent = '{0, 0, 0, 0, 0};

   function automatic int lat_of(int k);  return (k == 2) ? 1 : 4; endfunction
   function automatic bit fwb_of(int k);  return (k == 1) ? 0 : 1; endfunction

   function automatic bit writes(ent_t e, int x, bit used);
      return used && x != 0 && e.valid && e.wreg && e.dest == x;
   endfunction

   function automatic int exp_sel(int k, int x, bit used);
      if (writes(mex[k], x, used))                return 1;
      if (writes(mmem[k], x, used))               return 2;
      if (writes(mwb[k], x, used) && fwb_of(k))   return 3;
      return 0;
   endfunction

   function automatic bit exp_busy(int k);
      return mex[k].valid && mex[k].multi && mrem[k] > 0;
   endfunction

   function automatic bit wb_only(int k, int x, bit used);
      return !fwb_of(k) && writes(mwb[k], x, used) &&
             !writes(mex[k], x, used) && !writes(mmem[k], x, used);
   endfunction

   function automatic bit exp_stall(int k);
      bit lu;
      lu = mex[k].load && (writes(mex[k], int'(id_rs), id_rs_used) ||
                           writes(mex[k], int'(id_rt), id_rt_used));
      return id_valid && (lu || exp_busy(k) ||
                          wb_only(k, int'(id_rs), id_rs_used) ||
                          wb_only(k, int'(id_rt), id_rt_used));
   endfunction

   task automatic chk(string tag, logic [3:0] obs, logic [3:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cmp_all();
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("i%0d_fwd_a", k), 4'(fa[k]), 4'(exp_sel(k, int'(id_rs), id_rs_used)));
         chk($sformatf("i%0d_fwd_b", k), 4'(fb[k]), 4'(exp_sel(k, int'(id_rt), id_rt_used)));
         chk($sformatf("i%0d_stall", k), 4'(st[k]), 4'(exp_stall(k)));
         chk($sformatf("i%0d_flush", k), 4'(fl[k]),
             4'(id_valid && id_branch_taken && !exp_stall(k)));
         chk($sformatf("i%0d_busy", k), 4'(mb[k]), 4'(exp_busy(k)));
      end
   endtask

   task automatic drive(bit v, int rs, bit rsu, int rt, bit rtu, int rd,
                        bit w, bit ld, bit mu, bit br);
      id_valid = v;   id_rs = 5'(rs); id_rs_used = rsu;
      id_rt = 5'(rt); id_rt_used = rtu; id_rd = 5'(rd);
      id_wreg = w;    id_m2reg = ld;  id_multi = mu; id_branch_taken = br;
      #2;
      cmp_all();
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         automatic bit b = exp_busy(k);
         automatic bit s = exp_stall(k);
         if (rst) begin
            mex[k] = empty_ent; mmem[k] = empty_ent; mwb[k] = empty_ent; mrem[k] = 0;
         end else if (b) begin
            mrem[k] = mrem[k] - 1;
            mwb[k]  = mmem[k];
            mmem[k] = empty_ent;
         end else if (s) begin
            mwb[k]  = mmem[k];
            mmem[k] = mex[k];
            mex[k]  = empty_ent;
         end else begin
            mwb[k]  = mmem[k];
            mmem[k] = mex[k];
            mex[k]  = '{id_valid, int'(id_rd), id_wreg, id_m2reg, id_multi};
            if (id_valid && id_multi) mrem[k] = lat_of(k) - 1;
         end
      end
   endtask

   initial begin
      for (int k = 0; k < 3; k++) begin
         mex[k] = empty_ent; mmem[k] = empty_ent; mwb[k] = empty_ent; mrem[k] = 0;
      end

      // Reset, then idle ID
      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick(); tick();
      rst = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("rst_fwd_a", 4'(fa[0]), 4'h0);
      chk("rst_stall", 4'(st[0]), 4'h0);
      chk("rst_busy",  4'(mb[0]), 4'h0);
      chk("rst_flush", 4'(fl[0]), 4'h0);
      tick();

      // ADD r3, then consumers one, two and three cycles later
      drive(1, 1, 1, 2, 1, 3, 1, 0, 0, 0); tick();
      drive(1, 3, 1, 0, 0, 8, 1, 0, 0, 0);
      chk("add_ex_fwd_a", 4'(fa[0]), 4'h1); tick();
      drive(1, 0, 0, 3, 1, 9, 1, 0, 0, 0);
      chk("add_mem_fwd_b", 4'(fb[0]), 4'h2); tick();
      drive(1, 3, 1, 0, 0, 10, 1, 0, 0, 0);
      chk("add_wb_fwd_a", 4'(fa[0]), 4'h3);
      chk("nowb_stall", 4'(st[1]), 4'h1); tick();
      drive(1, 3, 1, 0, 0, 10, 1, 0, 0, 0);
      chk("nowb_release_stall", 4'(st[1]), 4'h0);
      chk("nowb_release_fwd_a", 4'(fa[1]), 4'h0); tick();

      // Load-use: one bubble, then MEM forward; rs=0 never stalls
      drive(1, 0, 0, 0, 0, 5, 1, 1, 0, 0); tick();
      drive(1, 5, 1, 0, 0, 6, 1, 0, 0, 0);
      chk("lu_stall", 4'(st[0]), 4'h1); tick();
      drive(1, 5, 1, 0, 0, 6, 1, 0, 0, 0);
      chk("lu_after_stall", 4'(st[0]), 4'h0);
      chk("lu_after_fwd_a", 4'(fa[0]), 4'h2); tick();
      drive(1, 0, 0, 0, 0, 5, 1, 1, 0, 0); tick();
      drive(1, 0, 1, 0, 0, 6, 1, 0, 0, 0);
      chk("lu_r0_stall", 4'(st[0]), 4'h0);
      chk("lu_r0_fwd_a", 4'(fa[0]), 4'h0); tick();

      // MUL r7 then dependent: three busy cycles, then EX forward
      drive(1, 0, 0, 0, 0, 7, 1, 0, 1, 0); tick();
      for (int c = 0; c < 3; c++) begin
         drive(1, 7, 1, 0, 0, 11, 1, 0, 0, 0);
         chk("mdu_busy", 4'(mb[0]), 4'h1);
         chk("mdu_stall", 4'(st[0]), 4'h1);
         tick();
      end
      drive(1, 7, 1, 0, 0, 11, 1, 0, 0, 0);
      chk("mdu_done_stall", 4'(st[0]), 4'h0);
      chk("mdu_done_fwd_a", 4'(fa[0]), 4'h1);
      chk("mdu_lat1_busy", 4'(mb[2]), 4'h0); tick();

      // Reset in the second busy cycle aborts the MDU op
      drive(1, 0, 0, 0, 0, 7, 1, 0, 1, 0); tick();
      drive(1, 7, 1, 0, 0, 11, 1, 0, 0, 0); tick();
      rst = 1'b1;
      drive(1, 7, 1, 0, 0, 11, 1, 0, 0, 0);
      chk("mdu_pre_rst_busy", 4'(mb[0]), 4'h1); tick();
      rst = 1'b0;
      drive(1, 7, 1, 0, 0, 11, 1, 0, 0, 0);
      chk("mdu_rst_busy", 4'(mb[0]), 4'h0);
      chk("mdu_rst_stall", 4'(st[0]), 4'h0); tick();

      // Taken branch behind a load-use stall flushes only when it issues
      drive(1, 0, 0, 0, 0, 5, 1, 1, 0, 0); tick();
      drive(1, 5, 1, 5, 1, 0, 0, 0, 0, 1);
      chk("br_stalled_flush", 4'(fl[0]), 4'h0); tick();
      drive(1, 5, 1, 5, 1, 0, 0, 0, 0, 1);
      chk("br_issue_flush", 4'(fl[0]), 4'h1); tick();

      // EX and MEM both write r4: youngest wins
      drive(1, 0, 0, 0, 0, 4, 1, 0, 0, 0); tick();
      drive(1, 0, 0, 0, 0, 4, 1, 0, 0, 0); tick();
      drive(1, 4, 1, 4, 1, 0, 0, 0, 0, 0);
      chk("young_fwd_a", 4'(fa[0]), 4'h1);
      chk("young_fwd_b", 4'(fb[0]), 4'h1); tick();

      // Randomised traffic over a small register window
      for (int n = 0; n < 600; n++) begin
         rst = ($urandom_range(0, 79) == 0);
         drive($urandom_range(0, 7) != 0,
               $urandom_range(0, 7), $urandom_range(0, 3) != 0,
               $urandom_range(0, 7), $urandom_range(0, 1),
               $urandom_range(0, 7), $urandom_range(0, 3) != 0,
               $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
               $urandom_range(0, 3) == 0);
         tick();
      end
      rst = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
